mux_arb_reg: RTL

// - Registered N-channel, WIDTH-bit data selector with valid/ready handshake on every channel and on the output.
// - Successor to the fixed 4:1 combinational mux. Select is generated internally by a round-robin or fixed-priority arbiter.
// - One-entry output register gives 1-cycle latency and full throughput.
// - Used wherever several producers (e.g. memory/IO return paths) share one consumer in the datapath.

---
 rtl/mux_arb_reg.sv | 113 +++++++++++
 1 files changed

// File: rtl/mux_arb_reg.sv
// mux_arb_reg: registered N-channel selector with an internal round-robin or
// fixed-priority arbiter. Every channel and the output use valid/ready.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high in the cycle before that edge. A producer keeps
// valid and data stable until it sees ready. valid never waits for ready.
// ready may depend combinationally on valid.
// Here in_ready depends only on in_valid, out_ready and the registered state.
// out_valid, out_data and out_sel come straight from flops.
module mux_arb_reg #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 32,
  parameter int RR_MODE = 1,
  parameter int SEL_W   = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic             load;
  logic             grant_found;
  logic [SEL_W-1:0] grant_idx;
  logic             xfer;

  // The output register can take a new word when empty or being emptied now.
  assign load = ~out_valid_q | out_ready;

  // Arbiter: in round-robin mode scan ptr..NUM_CH-1 first, then 0..ptr-1.
  // In fixed mode the first pass has no lower bound, so the lowest valid wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_found && in_valid[i] && ((RR_MODE == 0) || (i >= int'(ptr_q)))) begin
        grant_found = 1'b1;
        grant_idx   = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_found && in_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = SEL_W'(i);
      end
    end
  end

  // One-hot ready to the granted channel; held off entirely during reset so
  // no producer believes a word was taken while the register is being cleared.
  always_comb begin
    in_ready = '0;
    if (reset_n && load && grant_found) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  assign xfer = reset_n & load & grant_found;

  // Next-state for the output register and the priority pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = grant_found;
      if (grant_found) begin
        out_data_d = in_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_sel_d  = grant_idx;
        if (RR_MODE != 0) begin
          // Next search starts just after the winner, wrapping at NUM_CH-1.
          ptr_d = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + SEL_W'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

  // Transfer strobe is only meaningful together with in_ready; kept for
  // checker binding.
  logic unused_xfer;
  assign unused_xfer = xfer;

endmodule
